// File: rtl/prog_select.sv
// Pushbutton program selector: synchronises and debounces four buttons, then presents a
// one-shot program code for a fixed hold window. Debounce filters exist only with PROG_SELECT_DEBOUNCE_EN.
module prog_select #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [7:0]  HOLD_CYCLES     = 8'd4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btnl,
  input  logic        btnr,
  input  logic        btnu,
  input  logic        btnd,
  input  logic [15:0] sw,
  output logic [31:0] program_selector,
  output logic [15:0] sw_snapshot,
  output logic        busy
);

  // A zero hold length behaves like a single-cycle hold.
  localparam logic [7:0] HOLD_LAST = (HOLD_CYCLES == 8'd0) ? 8'd0 : HOLD_CYCLES - 8'd1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [3:0]  btn_s1, btn_s2;
  logic [15:0] sw_s1, sw_s2;
  logic [3:0]  deb, deb_d, rise;
  logic [7:0]  hold_cnt;
  logic [2:0]  code_q, code_sel;
  logic        trigger;

  // Bit order within the button vectors: 0 fib (btnl), 1 sort (btnr), 2 load (btnu), 3 save (btnd).
  always_ff @(posedge clock) begin
    if (reset) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= {btnd, btnu, btnr, btnl};
      btn_s2 <= btn_s1;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
    end
  end

`ifdef PROG_SELECT_DEBOUNCE_EN
  logic [3:0]  deb_q;
  logic [15:0] db_cnt [4];

  // The 17-bit compare avoids wrap-around when DEBOUNCE_CYCLES is zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      deb_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (btn_s2[i] != deb_q[i]) begin
          if (({1'b0, db_cnt[i]} + 17'd1) >= {1'b0, DEBOUNCE_CYCLES}) begin
            deb_q[i]  <= btn_s2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 16'd1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign deb = deb_q;
`else
  logic unused_debounce;
  assign unused_debounce = ^DEBOUNCE_CYCLES;
  assign deb = btn_s2;
`endif

  always_ff @(posedge clock) begin
    if (reset) deb_d <= '0;
    else       deb_d <= deb;
  end

  assign rise = deb & ~deb_d;

  always_comb begin
    code_sel = 3'd0;
    if      (rise[0]) code_sel = 3'd1;
    else if (rise[1]) code_sel = 3'd2;
    else if (rise[2]) code_sel = 3'd3;
    else if (rise[3]) code_sel = 3'd4;
  end

  // Edges outside IDLE are simply dropped; rise is a one-cycle pulse, so nothing queues.
  assign trigger = (state == IDLE) && (code_sel != 3'd0);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (trigger) state_next = HOLD;
      HOLD:    if (hold_cnt == 8'd0) state_next = RELEASE;
      RELEASE: if (deb == 4'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      code_q      <= '0;
      sw_snapshot <= '0;
      hold_cnt    <= '0;
    end else if (trigger) begin
      code_q      <= code_sel;
      sw_snapshot <= sw_s2;
      hold_cnt    <= HOLD_LAST;
    end else if ((state == HOLD) && (hold_cnt != 8'd0)) begin
      hold_cnt <= hold_cnt - 8'd1;
    end
  end

  always_comb begin
    program_selector = '0;
    busy             = (state != IDLE);
    if (state == HOLD) program_selector = {29'd0, code_q};
  end

endmodule

// File: tb/tb_prog_select.sv
// Self-checking bench for prog_select: directed scenarios plus randomized traffic against
// a cycle-level behavioural model. Works with or without PROG_SELECT_DEBOUNCE_EN.
module tb_prog_select;

  localparam int DB = 4;
  localparam int HC = 3;
`ifdef PROG_SELECT_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
  localparam int LAT    = 2 + DB + 1;
`else
  localparam bit DEB_EN = 1'b0;
  localparam int LAT    = 3;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        btnl = 1'b0, btnr = 1'b0, btnu = 1'b0, btnd = 1'b0;
  logic [15:0] sw = '0;
  logic [31:0] program_selector, ps0;
  logic [15:0] sw_snapshot, snap0;
  logic        busy, busy0;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  prog_select #(.DEBOUNCE_CYCLES(16'd4), .HOLD_CYCLES(8'd3)) dut (
    .clock(clock), .reset(reset),
    .btnl(btnl), .btnr(btnr), .btnu(btnu), .btnd(btnd), .sw(sw),
    .program_selector(program_selector), .sw_snapshot(sw_snapshot), .busy(busy)
  );

  // Second instance exercises the zero-length hold boundary.
  prog_select #(.DEBOUNCE_CYCLES(16'd4), .HOLD_CYCLES(8'd0)) dut0 (
    .clock(clock), .reset(reset),
    .btnl(btnl), .btnr(btnr), .btnu(btnu), .btnd(btnd), .sw(sw),
    .program_selector(ps0), .sw_snapshot(snap0), .busy(busy0)
  );

  // Behavioural model: buttons seen two cycles late, levels accepted after DB stable cycles,
  // then idle/hold/release modes described by plain counters.
  bit          m_p1[4], m_p2[4], m_deb[4], m_prev[4];
  int          m_run[4];
  logic [15:0] m_sw1 = '0, m_sw2 = '0, m_snap = '0;
  int          m_mode = 0, m_left = 0, m_code = 0;

  task automatic model_step();
    bit raw[4];
    bit lvl[4];
    int win;
    bit any_high;
    raw = '{btnl, btnr, btnu, btnd};
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_p1[i] = 0; m_p2[i] = 0; m_deb[i] = 0; m_prev[i] = 0; m_run[i] = 0;
      end
      m_sw1 = '0; m_sw2 = '0; m_snap = '0;
      m_mode = 0; m_left = 0; m_code = 0;
      return;
    end
    win = -1;
    any_high = 0;
    for (int i = 0; i < 4; i++) begin
      lvl[i] = DEB_EN ? m_deb[i] : m_p2[i];
      if (lvl[i]) any_high = 1;
    end
    for (int i = 3; i >= 0; i--) if (lvl[i] && !m_prev[i]) win = i;
    if (m_mode == 0) begin
      if (win >= 0) begin
        m_mode = 1; m_code = win + 1; m_snap = m_sw2; m_left = HC;
      end
    end else if (m_mode == 1) begin
      if (m_left <= 1) m_mode = 2;
      else m_left = m_left - 1;
    end else begin
      if (!any_high) m_mode = 0;
    end
    for (int i = 0; i < 4; i++) begin
      m_prev[i] = lvl[i];
      if (m_p2[i] != m_deb[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] >= DB) begin
          m_deb[i] = m_p2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_p2[i] = m_p1[i];
      m_p1[i] = raw[i];
    end
    m_sw2 = m_sw1;
    m_sw1 = sw;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    {btnl, btnr, btnu, btnd} = 4'b0;
    sw = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btnl = 1'b1;
    sw = 16'hBEEF;
    tick();
    tick();
    tick();
    checks++;
    if (program_selector !== 32'd0) begin
      failures++; $display("[TB] FAIL reset_ps got=%0d exp=0", program_selector);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy);
    end
    checks++;
    if (sw_snapshot !== 16'h0000) begin
      failures++; $display("[TB] FAIL reset_snap got=%h exp=0000", sw_snapshot);
    end
    btnl = 1'b0;
    sw = '0;
    reset = 1'b0;
    for (int n = 0; n < 10; n++) tick();
  endtask

  task automatic test_fib();
    logic [31:0] exp_ps, exp_ps0;
    logic        exp_busy;
    do_reset();
    btnl = 1'b1;
    sw = 16'h0503;
    for (int n = 1; n <= 40; n++) begin
      tick();
      exp_ps   = (n >= LAT && n < LAT + HC) ? 32'd1 : 32'd0;
      exp_ps0  = (n == LAT) ? 32'd1 : 32'd0;
      exp_busy = (n >= LAT && n < 20 + LAT);
      checks++;
      if (program_selector !== exp_ps) begin
        failures++; $display("[TB] FAIL fib_ps n=%0d got=%0d exp=%0d", n, program_selector, exp_ps);
      end
      checks++;
      if (ps0 !== exp_ps0) begin
        failures++; $display("[TB] FAIL hold0_ps n=%0d got=%0d exp=%0d", n, ps0, exp_ps0);
      end
      checks++;
      if (busy !== exp_busy) begin
        failures++; $display("[TB] FAIL fib_busy n=%0d got=%b exp=%b", n, busy, exp_busy);
      end
      if (n == LAT || n == 40) begin
        checks++;
        if (sw_snapshot !== 16'h0503) begin
          failures++; $display("[TB] FAIL fib_snap n=%0d got=%h exp=0503", n, sw_snapshot);
        end
      end
      if (n == 20) btnl = 1'b0;
      if (n == 25) sw = 16'h1234;
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] exp_ps;
    do_reset();
    btnr = 1'b1;
    btnd = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      exp_ps = (n >= LAT && n < LAT + HC) ? 32'd2 : 32'd0;
      checks++;
      if (program_selector !== exp_ps) begin
        failures++; $display("[TB] FAIL simul_ps n=%0d got=%0d exp=%0d", n, program_selector, exp_ps);
      end
      if (n == 20) begin
        btnr = 1'b0;
        btnd = 1'b0;
      end
    end
  endtask

`ifdef PROG_SELECT_DEBOUNCE_EN
  task automatic test_bounce();
    logic [31:0] exp_ps;
    do_reset();
    for (int n = 1; n <= 40; n++) begin
      btnu = (n == 1 || n == 3 || (n >= 5 && n <= 14));
      tick();
      exp_ps = (n >= 4 + LAT && n < 4 + LAT + HC) ? 32'd3 : 32'd0;
      checks++;
      if (program_selector !== exp_ps) begin
        failures++; $display("[TB] FAIL bounce_ps n=%0d got=%0d exp=%0d", n, program_selector, exp_ps);
      end
    end
    btnu = 1'b0;
  endtask
`else
  task automatic test_no_debounce();
    logic [31:0] exp_ps;
    logic        exp_busy;
    do_reset();
    for (int n = 1; n <= 15; n++) begin
      btnu = (n <= 5);
      tick();
      exp_ps   = (n >= 3 && n <= 5) ? 32'd3 : 32'd0;
      exp_busy = (n >= 3 && n <= 7);
      checks++;
      if (program_selector !== exp_ps) begin
        failures++; $display("[TB] FAIL nodeb_ps n=%0d got=%0d exp=%0d", n, program_selector, exp_ps);
      end
      checks++;
      if (busy !== exp_busy) begin
        failures++; $display("[TB] FAIL nodeb_busy n=%0d got=%b exp=%b", n, busy, exp_busy);
      end
    end
    btnu = 1'b0;
  endtask
`endif

  task automatic test_reset_abort();
    logic [31:0] exp_ps;
    do_reset();
    btnd = 1'b1;
    sw = 16'h00A5;
    for (int n = 1; n <= LAT + 1; n++) tick();
    checks++;
    if (program_selector !== 32'd4) begin
      failures++; $display("[TB] FAIL abort_pre_ps got=%0d exp=4", program_selector);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (program_selector !== 32'd0 || busy !== 1'b0 || sw_snapshot !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL abort_outputs got ps=%0d busy=%b snap=%h exp ps=0 busy=0 snap=0000",
               program_selector, busy, sw_snapshot);
    end
    for (int m = 1; m <= LAT + HC + 5; m++) begin
      tick();
      exp_ps = (m >= LAT && m < LAT + HC) ? 32'd4 : 32'd0;
      checks++;
      if (program_selector !== exp_ps) begin
        failures++; $display("[TB] FAIL abort_retrig m=%0d got=%0d exp=%0d", m, program_selector, exp_ps);
      end
    end
    btnd = 1'b0;
    for (int n = 0; n < 15; n++) tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_ps;
    do_reset();
    for (int n = 1; n <= 60; n++) begin
      btnr = (n <= 20);
      btnl = (n >= 12 && n <= 20);
      tick();
      exp_ps = (n >= LAT && n < LAT + HC) ? 32'd2 : 32'd0;
      checks++;
      if (program_selector !== exp_ps) begin
        failures++; $display("[TB] FAIL release_ign_ps n=%0d got=%0d exp=%0d", n, program_selector, exp_ps);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("[TB] FAIL release_idle_busy got=%b exp=0", busy);
    end
    btnl = 1'b1;
    for (int n = 1; n <= LAT + HC + 2; n++) begin
      tick();
      exp_ps = (n >= LAT && n < LAT + HC) ? 32'd1 : 32'd0;
      checks++;
      if (program_selector !== exp_ps) begin
        failures++; $display("[TB] FAIL repress_ps n=%0d got=%0d exp=%0d", n, program_selector, exp_ps);
      end
    end
    btnl = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] exp_ps;
    logic        exp_busy;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) btnl = ~btnl;
      if ($urandom_range(0, 7) == 0) btnr = ~btnr;
      if ($urandom_range(0, 7) == 0) btnu = ~btnu;
      if ($urandom_range(0, 7) == 0) btnd = ~btnd;
      if ($urandom_range(0, 3) == 0) sw = 16'($urandom);
      reset = ($urandom_range(0, 399) == 0);
      tick();
      exp_ps   = (m_mode == 1) ? 32'(m_code) : 32'd0;
      exp_busy = (m_mode != 0);
      checks++;
      if (program_selector !== exp_ps) begin
        failures++; $display("[TB] FAIL rand_ps n=%0d got=%0d exp=%0d", n, program_selector, exp_ps);
      end
      checks++;
      if (busy !== exp_busy) begin
        failures++; $display("[TB] FAIL rand_busy n=%0d got=%b exp=%b", n, busy, exp_busy);
      end
      checks++;
      if (sw_snapshot !== m_snap) begin
        failures++; $display("[TB] FAIL rand_snap n=%0d got=%h exp=%h", n, sw_snapshot, m_snap);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    $display("[TB] starting prog_select bench, debounce_en=%0d", DEB_EN);
    test_reset();
    test_fib();
    test_simultaneous();
`ifdef PROG_SELECT_DEBOUNCE_EN
    test_bounce();
`else
    test_no_debounce();
`endif
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
